// File: rtl/operand_fetch.sv
// Operand fetch stage: selects ALU source/destination operands and
// forms the registered memory address driven onto the MAB.
module operand_fetch #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Rsrc,
    input  logic [WIDTH-1:0] Rdst,
    input  logic [WIDTH-1:0] MDB,
    input  logic             srcM,
    input  logic             srcL,
    input  logic             dstM,
    input  logic             dstL,
    input  logic [1:0]       AddrM,
    input  logic             AddrL,
    input  logic             IdxM,
    output logic [WIDTH-1:0] OpSrc,
    output logic [WIDTH-1:0] OpDst,
    output logic [WIDTH-1:0] MAB
);

    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] dst_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] addr_d;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] offs;

    always_comb begin
        base = Rsrc;
        unique case (AddrM)
            2'd0: base = Rsrc;
            2'd1: base = Rdst;
            2'd2: base = MDB;
            2'd3: base = addr_q;
        endcase
    end

    // Carry out of the indexed add is dropped: addresses wrap mod 2^WIDTH.
    assign offs   = IdxM ? MDB : '0;
    assign addr_d = base + offs;

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            addr_q <= '0;
        end else begin
            if (srcL)  src_q  <= MDB;
            if (dstL)  dst_q  <= MDB;
            if (AddrL) addr_q <= addr_d;
        end
    end

    // Latched operands come only from the registers, never bypassed from MDB.
    assign OpSrc = srcM ? src_q : Rsrc;
    assign OpDst = dstM ? dst_q : Rdst;
    assign MAB   = addr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch with a few
// hand-written same-cycle timing sequences.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Rsrc, Rdst, MDB;
    logic        srcM, srcL, dstM, dstL;
    logic [1:0]  AddrM;
    logic        AddrL, IdxM;
    logic [15:0] OpSrc, OpDst, MAB;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    operand_fetch #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .Rsrc(Rsrc), .Rdst(Rdst), .MDB(MDB),
        .srcM(srcM), .srcL(srcL),
        .dstM(dstM), .dstL(dstL),
        .AddrM(AddrM), .AddrL(AddrL), .IdxM(IdxM),
        .OpSrc(OpSrc), .OpDst(OpDst), .MAB(MAB)
    );

    typedef struct {
        logic        r;
        logic [15:0] rs, rd, mdb;
        logic        sm, sl, dm, dl;
        logic [1:0]  am;
        logic        al, im;
        logic [15:0] es, ed, ea;
        logic        chk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic [15:0] rs, rd, mdb,
        input logic sm, sl, dm, dl,
        input logic [1:0] am, input logic al, im,
        input logic [15:0] es, ed, ea, input logic chk);
        vec_t v;
        v.r = r; v.rs = rs; v.rd = rd; v.mdb = mdb;
        v.sm = sm; v.sl = sl; v.dm = dm; v.dl = dl;
        v.am = am; v.al = al; v.im = im;
        v.es = es; v.ed = ed; v.ea = ea; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; Rsrc = v.rs; Rdst = v.rd; MDB = v.mdb;
        srcM = v.sm; srcL = v.sl; dstM = v.dm; dstL = v.dl;
        AddrM = v.am; AddrL = v.al; IdxM = v.im;
    endtask

    initial begin
        // Each row: inputs, then OpSrc/OpDst/MAB expected before the edge.
        //          r  Rsrc     Rdst   MDB      sM sL dM dL AM AL Ix  eSrc     eDst     eMAB     chk
        vecs.push_back(mk(0, 16'd40, 16'd80, 16'd120, 0,0,0,0, 2'd0,0,0, 16'd0, 16'd0, 16'd0, 0));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,0,0, 2'd0,0,0, 16'd40, 16'd80, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 1,0,0,0, 2'd0,0,0, 16'd0, 16'd80, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 1,1,0,0, 2'd0,0,0, 16'd0, 16'd80, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 1,0,0,0, 2'd0,0,0, 16'd120, 16'd80, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,0,0, 2'd0,0,0, 16'd40, 16'd80, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,0,1, 2'd0,0,0, 16'd40, 16'd80, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,1,0, 2'd0,0,0, 16'd40, 16'd120, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd7,   0,0,1,0, 2'd0,0,0, 16'd40, 16'd120, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,1,0, 2'd0,1,0, 16'd40, 16'd120, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,1,0, 2'd0,1,1, 16'd40, 16'd120, 16'd40, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,1,0, 2'd3,1,0, 16'd40, 16'd120, 16'd160, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,1,0, 2'd2,0,0, 16'd40, 16'd120, 16'd160, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,1,0, 2'd1,1,0, 16'd40, 16'd120, 16'd160, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd120, 0,0,1,0, 2'd2,1,0, 16'd40, 16'd120, 16'd80, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'd5,   0,0,1,0, 2'd3,1,1, 16'd40, 16'd120, 16'd120, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'h0101, 0,0,1,0, 2'd2,1,1, 16'd40, 16'd120, 16'd125, 1));
        vecs.push_back(mk(1, 16'hFFF0, 16'd80, 16'h0020, 0,0,1,0, 2'd0,1,1, 16'hFFF0, 16'd120, 16'h0202, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'hBEEF, 1,1,1,1, 2'd1,1,0, 16'd120, 16'd120, 16'h0010, 1));
        vecs.push_back(mk(0, 16'd40, 16'd80, 16'h1234, 1,1,1,1, 2'd2,1,0, 16'hBEEF, 16'hBEEF, 16'd80, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'h1234, 1,1,1,1, 2'd2,1,0, 16'd0, 16'd0, 16'd0, 1));
        vecs.push_back(mk(1, 16'd40, 16'd80, 16'h1234, 1,0,1,0, 2'd2,0,0, 16'h1234, 16'h1234, 16'h1234, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d OpSrc", i), OpSrc, vecs[i].es);
                check($sformatf("v%0d OpDst", i), OpDst, vecs[i].ed);
                check($sformatf("v%0d MAB", i), MAB, vecs[i].ea);
            end
        end

        // Register path tracks Rsrc/Rdst changes within the same cycle.
        @(negedge clk);
        srcM = 0; dstM = 0; AddrL = 0;
        Rsrc = 16'h0AAA; #1;
        check("seq Rsrc live", OpSrc, 16'h0AAA);
        Rdst = 16'h5555; #1;
        check("seq Rdst live", OpDst, 16'h5555);
        srcM = 1; #1;
        check("seq srcM live", OpSrc, 16'h1234);

        // Address input changes must not reach MAB before the edge.
        AddrL = 1; AddrM = 2'd0; IdxM = 1; MDB = 16'h0006; #1;
        check("seq MAB no comb", MAB, 16'h1234);
        @(posedge clk); #1;
        check("seq MAB idx", MAB, 16'h0AB0);
        @(negedge clk);
        AddrL = 0; AddrM = 2'd3; #1;
        @(posedge clk); #1;
        check("seq MAB hold", MAB, 16'h0AB0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
